// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                      |
// | Purpose  : Shared state codes, frame constants and helpers for the UART. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned c_ST_W       = 3;
    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_START   = 3'd1;
    localparam logic [2:0]  c_ST_DATA    = 3'd2;
    localparam logic [2:0]  c_ST_PARITY  = 3'd3;
    localparam logic [2:0]  c_ST_STOP    = 3'd4;

    localparam int unsigned c_DBITS_BASE = 5;
    localparam int unsigned c_DATA_W     = 8;
    localparam int unsigned c_DIV_W_DEF  = 16;

    // Keeps only the low 5+dbits bits of a byte.
    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        data_mask = 8'hFF >> (2'd3 - dbits);
    endfunction

    // Index of the final data bit of a frame.
    function automatic logic [2:0] last_bit(input logic [1:0] dbits);
        last_bit = 3'(c_DBITS_BASE - 1) + {1'b0, dbits};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_fifo                                                     |
// | Purpose  : Power-of-two FIFO with first-word fall-through head output.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL  = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (c_AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_core_param                                               |
// | Purpose  : Full-duplex UART: baud tick, TX/RX framers, TX/RX FIFOs.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_core_param
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = c_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       dbits,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             stop2,
    input  logic             txen,
    input  logic             rxen,
    output logic             tx,
    input  logic             rx,
    input  logic             write,
    input  logic [7:0]       wrdata,
    output logic             isfull,
    output logic             txbusy,
    input  logic             read,
    output logic [7:0]       rddata,
    output logic             datardy,
    output logic             perr,
    output logic             ferr,
    output logic             overrun,
    input  logic             errclr
);

    localparam int              c_OS_W    = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0] c_OS_HALF = c_OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [c_OS_W-1:0] c_OS_ONE  = c_OS_W'(1);

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] r_tick_cnt;
    logic [DIV_W-1:0] r_div_cur;
    logic             w_tick;

    assign w_tick = en && (r_tick_cnt == r_div_cur);

    // The divisor is only reloaded at a wrap so a period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_div_cur  <= '0;
        end else if (!en || w_tick) begin
            r_tick_cnt <= '0;
            r_div_cur  <= div;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
    end

    // ---------------- FIFOs ----------------
    logic       w_tx_empty;
    logic       w_tx_full;
    logic [7:0] w_tx_head;
    logic       w_tx_launch;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_rx_store;
    logic [7:0] r_rx_data;

    uart_fifo #(.WIDTH(c_DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (write),
        .i_push_data (wrdata),
        .i_pop       (w_tx_launch),
        .o_head      (w_tx_head),
        .o_empty     (w_tx_empty),
        .o_full      (w_tx_full)
    );

    uart_fifo #(.WIDTH(c_DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_rx_store),
        .i_push_data (r_rx_data),
        .i_pop       (read),
        .o_head      (rddata),
        .o_empty     (w_rx_empty),
        .o_full      (w_rx_full)
    );

    assign isfull  = w_tx_full;
    assign datardy = !w_rx_empty;

    // ---------------- TX framer ----------------
    logic [c_ST_W-1:0] r_tx_state;
    logic [c_OS_W-1:0] r_tx_os;
    logic [2:0]        r_tx_bit;
    logic [2:0]        r_tx_last;
    logic [7:0]        r_tx_shift;
    logic              r_tx_par;
    logic              r_tx_paren;
    logic              r_tx_stop2;
    logic              r_tx_stop_more;
    logic              r_tx;
    logic              w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_os == c_OS_LAST);
    // A new frame may start from IDLE or straight out of the final stop bit.
    assign w_tx_launch  = w_tick && txen && !w_tx_empty &&
                          ((r_tx_state == c_ST_IDLE) ||
                           ((r_tx_state == c_ST_STOP) && w_tx_bit_end && !r_tx_stop_more));
    assign tx     = r_tx;
    assign txbusy = (r_tx_state != c_ST_IDLE) || !w_tx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state     <= c_ST_IDLE;
            r_tx_os        <= '0;
            r_tx_bit       <= '0;
            r_tx_last      <= '0;
            r_tx_shift     <= '0;
            r_tx_par       <= 1'b0;
            r_tx_paren     <= 1'b0;
            r_tx_stop2     <= 1'b0;
            r_tx_stop_more <= 1'b0;
            r_tx           <= 1'b1;
        end else if (!en) begin
            r_tx_state     <= c_ST_IDLE;
            r_tx_os        <= '0;
            r_tx_stop_more <= 1'b0;
            r_tx           <= 1'b1;
        end else if (w_tx_launch) begin
            r_tx_state <= c_ST_START;
            r_tx_os    <= '0;
            r_tx       <= 1'b0;
            r_tx_shift <= w_tx_head & data_mask(dbits);
            r_tx_par   <= (^(w_tx_head & data_mask(dbits))) ^ par_odd;
            r_tx_last  <= last_bit(dbits);
            r_tx_paren <= par_en;
            r_tx_stop2 <= stop2;
        end else if (w_tick && (r_tx_state != c_ST_IDLE)) begin
            if (!w_tx_bit_end) begin
                r_tx_os <= r_tx_os + c_OS_ONE;
            end else begin
                r_tx_os <= '0;
                case (r_tx_state)
                    c_ST_START: begin
                        r_tx_state <= c_ST_DATA;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                    end
                    c_ST_DATA: begin
                        if (r_tx_bit == r_tx_last) begin
                            if (r_tx_paren) begin
                                r_tx_state <= c_ST_PARITY;
                                r_tx       <= r_tx_par;
                            end else begin
                                r_tx_state     <= c_ST_STOP;
                                r_tx           <= 1'b1;
                                r_tx_stop_more <= r_tx_stop2;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end
                    c_ST_PARITY: begin
                        r_tx_state     <= c_ST_STOP;
                        r_tx           <= 1'b1;
                        r_tx_stop_more <= r_tx_stop2;
                    end
                    c_ST_STOP: begin
                        if (r_tx_stop_more) r_tx_stop_more <= 1'b0;
                        else                r_tx_state     <= c_ST_IDLE;
                    end
                    default: r_tx_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX framer ----------------
    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_s3;
    logic [c_ST_W-1:0] r_rx_state;
    logic [c_OS_W-1:0] r_rx_os;
    logic [2:0]        r_rx_bit;
    logic [2:0]        r_rx_last;
    logic              r_rx_paren;
    logic              r_rx_odd;
    logic              r_perr;
    logic              r_ferr;
    logic              r_overrun;
    logic              w_rx_live;
    logic              w_rx_sample;
    logic              w_perr_set;
    logic              w_ferr_set;
    logic              w_ovr_set;

    assign w_rx_live   = en && rxen;
    // Start is resampled half a bit in; every later bit one full bit apart.
    assign w_rx_sample = w_tick && (r_rx_os == ((r_rx_state == c_ST_START) ? c_OS_HALF : c_OS_LAST));
    assign w_rx_store  = w_rx_live && w_rx_sample && (r_rx_state == c_ST_STOP);
    assign w_ferr_set  = w_rx_store && !r_rx_s2;
    assign w_perr_set  = w_rx_live && w_rx_sample && (r_rx_state == c_ST_PARITY) &&
                         (((^r_rx_data) ^ r_rx_s2) != r_rx_odd);
    assign w_ovr_set   = w_rx_store && w_rx_full && !(read && !w_rx_empty);

    assign perr    = r_perr;
    assign ferr    = r_ferr;
    assign overrun = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_s3   <= 1'b1;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_s3   <= r_rx_s2;
            r_perr    <= w_perr_set | (r_perr    & ~errclr);
            r_ferr    <= w_ferr_set | (r_ferr    & ~errclr);
            r_overrun <= w_ovr_set  | (r_overrun & ~errclr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= c_ST_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_last  <= '0;
            r_rx_paren <= 1'b0;
            r_rx_odd   <= 1'b0;
            r_rx_data  <= '0;
        end else if (!w_rx_live) begin
            r_rx_state <= c_ST_IDLE;
            r_rx_os    <= '0;
        end else if (r_rx_state == c_ST_IDLE) begin
            if (r_rx_s3 && !r_rx_s2) begin
                r_rx_state <= c_ST_START;
                r_rx_os    <= '0;
                r_rx_data  <= '0;
                r_rx_last  <= last_bit(dbits);
                r_rx_paren <= par_en;
                r_rx_odd   <= par_odd;
            end
        end else if (w_tick) begin
            if (!w_rx_sample) begin
                r_rx_os <= r_rx_os + c_OS_ONE;
            end else begin
                r_rx_os <= '0;
                case (r_rx_state)
                    c_ST_START: begin
                        r_rx_state <= r_rx_s2 ? c_ST_IDLE : c_ST_DATA;
                        r_rx_bit   <= '0;
                    end
                    c_ST_DATA: begin
                        r_rx_data[r_rx_bit] <= r_rx_s2;
                        if (r_rx_bit == r_rx_last)
                            r_rx_state <= r_rx_paren ? c_ST_PARITY : c_ST_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 3'd1;
                    end
                    c_ST_PARITY: r_rx_state <= c_ST_STOP;
                    default:     r_rx_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_core_param                                            |
// | Purpose  : Directed self-checking bench with a frame-level UART model.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_core_param;

    localparam int FD = 16;
    localparam int OS = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] div = '0;
    logic [1:0]    dbits = 2'd3;
    logic          par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
    logic          txen = 1'b0, rxen = 1'b0;
    logic          tx, rx;
    logic          write = 1'b0;
    logic [7:0]    wrdata = '0;
    logic          isfull, txbusy;
    logic          read = 1'b0;
    logic [7:0]    rddata;
    logic          datardy, perr, ferr, overrun;
    logic          errclr = 1'b0;
    logic          loopback = 1'b0;
    logic          rx_drv = 1'b1;

    int vectors = 0;
    int errors  = 0;

    assign rx = loopback ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_core_param #(.FIFO_DEPTH(FD), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .dbits(dbits),
        .par_en(par_en), .par_odd(par_odd), .stop2(stop2), .txen(txen), .rxen(rxen),
        .tx(tx), .rx(rx), .write(write), .wrdata(wrdata), .isfull(isfull),
        .txbusy(txbusy), .read(read), .rddata(rddata), .datardy(datardy),
        .perr(perr), .ferr(ferr), .overrun(overrun), .errclr(errclr)
    );

    // The single comparison point of the bench.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial line model: start, LSB-first data, optional parity, stop bit(s).
    function automatic void frame(input logic [7:0] b, input int nb, input bit pe,
                                  input bit odd, input bit s2,
                                  output logic [11:0] bits, output int len);
        int ones;
        ones = 0;
        bits = '0;
        len  = 0;
        bits[len] = 1'b0; len++;
        for (int i = 0; i < nb; i++) begin
            bits[len] = b[i];
            if (b[i]) ones++;
            len++;
        end
        if (pe) begin
            bits[len] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            len++;
        end
        bits[len] = 1'b1; len++;
        if (s2) begin bits[len] = 1'b1; len++; end
    endfunction

    task automatic host_write(input logic [7:0] b);
        @(posedge clk); #1 write = 1'b1; wrdata = b;
        @(posedge clk); #1 write = 1'b0;
    endtask

    task automatic host_read();
        @(posedge clk); #1 read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
    endtask

    task automatic pulse_errclr();
        @(posedge clk); #1 errclr = 1'b1;
        @(posedge clk); #1 errclr = 1'b0;
    endtask

    task automatic wait_tx_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rdy(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (datardy === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Finds the start bit, then checks every cycle of every bit of the frame.
    task automatic check_tx_frame(input logic [7:0] b, input int bitcyc, input int limit);
        logic [11:0] bits;
        int len, bad;
        bit ok;
        frame(b, 5 + int'(dbits), par_en, par_odd, stop2, bits, len);
        wait_tx_low(limit, ok);
        check($sformatf("tx_%02h_start_found", b), ok, 1);
        if (!ok) return;
        for (int k = 0; k < len; k++) begin
            bad = 0;
            for (int c = 0; c < bitcyc; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (tx !== bits[k]) bad++;
            end
            check($sformatf("tx_%02h_bit%0d_bad_cycles", b, k), bad, 0);
        end
    endtask

    task automatic send_rx(input logic [11:0] bits, input int len, input int bitcyc);
        for (int k = 0; k < len; k++) begin
            rx_drv = bits[k];
            repeat (bitcyc) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (2 * bitcyc) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] bits;
        int len;
        bit ok;
        logic [7:0] exp_q[$];
        bit exp_ovr;

        // Model pins: hand-derived serial images.
        frame(8'h55, 8, 0, 0, 0, bits, len);
        check("model_55_8N1", {bits, 4'(len)}, {12'h2AA, 4'd10});
        frame(8'hA3, 8, 1, 1, 1, bits, len);
        check("model_A3_8O2", {bits, 4'(len)}, {12'hF46, 4'd12});
        frame(8'h3C, 7, 1, 0, 0, bits, len);
        check("model_3C_7E1", {bits, 4'(len)}, {12'h278, 4'd10});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_flags", {isfull, txbusy, datardy, perr, ferr, overrun}, 6'b0);
        check("rst_rddata", rddata, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        en = 1'b1; txen = 1'b1;

        // T1: 8N1 0x55, DIV=0
        host_write(8'h55);
        check("t1_busy_after_write", txbusy, 1);
        @(negedge clk);
        check("t1_idle_before_pop", tx, 1);
        check_tx_frame(8'h55, OS, 2);
        check("t1_busy_last_cycle", txbusy, 1);
        @(negedge clk);
        check("t1_busy_fall", txbusy, 0);

        // T2: loopback 8O2 0xA3
        loopback = 1'b1; rxen = 1'b1; par_en = 1'b1; par_odd = 1'b1; stop2 = 1'b1;
        host_write(8'hA3);
        check_tx_frame(8'hA3, OS, 6);
        wait_rdy(64, ok);
        check("t2_datardy", ok, 1);
        check("t2_rddata", rddata, 8'hA3);
        check("t2_errs", {perr, ferr}, 2'b00);
        host_read();
        @(negedge clk);
        check("t2_empty_after_read", datardy, 0);
        loopback = 1'b0;

        // T3: fill TX FIFO with transmitter disabled
        par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; txen = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            write = 1'b1; wrdata = 8'(i);
            @(posedge clk); #1;
            if (i == 14) check("t3_notfull_15", isfull, 0);
            if (i == 15) check("t3_full_16", isfull, 1);
        end
        write = 1'b0;
        check("t3_still_full", isfull, 1);
        txen = 1'b1;
        for (int i = 0; i < 16; i++) check_tx_frame(8'(i), OS, (i == 0) ? 4 : 1);
        @(negedge clk);
        check("t3_done_no_extra", {txbusy, tx}, 2'b01);

        // T4: 7E1 framing error, then parity error, then clear
        dbits = 2'd2; par_en = 1'b1; par_odd = 1'b0;
        frame(8'h3C, 7, 1, 0, 0, bits, len);
        bits[9] = 1'b0;
        send_rx(bits, len, OS);
        check("t4_ferr", {ferr, perr}, 2'b10);
        check("t4_rdy", datardy, 1);
        check("t4_data", rddata, 8'h3C);
        host_read();
        frame(8'h3C, 7, 1, 0, 0, bits, len);
        bits[8] = ~bits[8];
        send_rx(bits, len, OS);
        check("t4_perr", {ferr, perr}, 2'b11);
        check("t4_data2", rddata, 8'h3C);
        host_read();
        pulse_errclr();
        check("t4_cleared", {ferr, perr, datardy}, 3'b000);

        // T5: 17 RX frames without reads, queue model decides storage
        dbits = 2'd3; par_en = 1'b0;
        exp_ovr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            frame(8'(8'h80 + i), 8, 0, 0, 0, bits, len);
            send_rx(bits, len, OS);
            if (exp_q.size() < FD) exp_q.push_back(8'(8'h80 + i));
            else exp_ovr = 1'b1;
            if (i == 15 || i == 16) check($sformatf("t5_overrun_after_%0d", i + 1), overrun, exp_ovr);
        end
        for (int i = 0; i < FD; i++) begin
            check($sformatf("t5_rd%0d_rdy", i), datardy, 1);
            check($sformatf("t5_rd%0d_data", i), rddata, exp_q.pop_front());
            host_read();
        end
        check("t5_drained", datardy, 0);
        pulse_errclr();
        check("t5_ovr_cleared", overrun, 0);

        // T5b: DIV=3 -> 64-cycle bits
        div = 16'd3;
        host_write(8'h55);
        check_tx_frame(8'h55, 4 * OS, 12);
        @(negedge clk);
        check("t5b_busy_fall", txbusy, 0);
        div = '0;

        // T6: short RX glitch is not a frame
        @(posedge clk); #1 rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (3 * OS) @(posedge clk);
        #1;
        check("t6_glitch_nodata", {datardy, ferr, perr}, 3'b000);

        // T6b: async reset mid-frame with RX data and a sticky error pending
        frame(8'h5A, 8, 0, 0, 0, bits, len);
        bits[9] = 1'b0;
        send_rx(bits, len, OS);
        check("t6_pre_state", {datardy, ferr}, 2'b11);
        host_write(8'h55);
        host_write(8'h66);
        wait_tx_low(8, ok);
        check("t6_tx_started", ok, 1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx", tx, 1);
        check("t6_rst_flags", {isfull, txbusy, datardy, perr, ferr, overrun}, 6'b0);
        check("t6_rst_rddata", rddata, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (4 * OS) @(negedge clk);
        check("t6_post_idle", {tx, txbusy}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
